// File: rtl/jtbubl_rom_pkg.sv
// Shared definitions for the jtbubl ROM read slots: FSM encoding,
// per-region SDRAM offsets and the line-to-SDRAM address mapping.
package jtbubl_rom_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [21:0] MAIN_OFFSET = 22'h0;
  localparam logic [21:0] SND_OFFSET  = 22'h1_0000;
  localparam logic [21:0] GFX1_OFFSET = 22'h1_4000;
  localparam logic [21:0] GFX2_OFFSET = 22'h5_4000;

  // One line is 32 bits, i.e. two 16-bit SDRAM words; wraps modulo 2^22.
  function automatic logic [21:0] line_to_sdram(input logic [21:0] offset,
                                                input logic [21:0] line);
    return offset + {line[20:0], 1'b0};
  endfunction

endpackage

// File: rtl/jtbubl_rom_line.sv
// One cache entry of a ROM slot: tag, valid bit, 32-bit line data,
// tag match and the DW-bit lane multiplexer.
module jtbubl_rom_line #(
  parameter int DW = 8,
  parameter int LW = 15,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_wr_en,
  input  logic [LW-1:0] i_wr_tag,
  input  logic [31:0]   i_wr_data,
  input  logic [LW-1:0] i_line,
  input  logic [SW-1:0] i_sel,
  output logic          o_match,
  output logic [DW-1:0] o_lane
);

  logic          r_valid;
  logic [LW-1:0] r_tag;
  logic [31:0]   r_data;
  logic [31:0]   w_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_wr_en) begin
      r_valid <= 1'b1;
      r_tag   <= i_wr_tag;
      r_data  <= i_wr_data;
    end
  end

  assign o_match = r_valid && (r_tag == i_line);

  // Lowest select value lives in the least significant lane.
  assign w_shift = r_data >> (DW * int'(i_sel));
  assign o_lane  = w_shift[DW-1:0];

endmodule

// File: rtl/jtbubl_rom_slot.sv
// SDRAM read slot with a 2-entry LRU line cache; converts client
// addr/cs into 32-bit line fetches over the req/ack/data_rdy bus.
module jtbubl_rom_slot
  import jtbubl_rom_pkg::*;
#(
  parameter int          AW     = 17,
  parameter int          DW     = 8,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic          ok,
  output logic [DW-1:0] dout,
  output logic          req,
  output logic [21:0]   sdram_addr,
  input  logic          ack,
  input  logic          data_rdy,
  input  logic [31:0]   data_read
);

  localparam int SW = (DW == 8) ? 2 : 1;
  localparam int LW = AW - SW;

  if (DW != 8 && DW != 16) begin : g_bad_dw
    $error("jtbubl_rom_slot: DW must be 8 or 16");
  end

  state_t        r_state;
  logic          r_lru;
  logic          r_drop;
  logic [LW-1:0] r_pend_tag;

  logic [LW-1:0] w_line;
  logic [SW-1:0] w_sel;
  logic [1:0]    w_match;
  logic [DW-1:0] w_lane [2];
  logic          w_any_match;
  logic          w_hit;
  logic          w_fill;
  logic          w_byp;
  logic [31:0]   w_byp_shift;
  logic [DW-1:0] w_byp_lane;
  logic [DW-1:0] w_hit_lane;

  assign w_line = addr[AW-1:SW];
  assign w_sel  = addr[SW-1:0];

  // A fetch that saw a flush at any point is dropped: its data predates the download.
  assign w_fill = (r_state == WAIT) && data_rdy && !flush && !r_drop;

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    jtbubl_rom_line #(
      .DW(DW),
      .LW(LW),
      .SW(SW)
    ) u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (flush),
      .i_wr_en  (w_fill && (r_lru == 1'(gi))),
      .i_wr_tag (r_pend_tag),
      .i_wr_data(data_read),
      .i_line   (w_line),
      .i_sel    (w_sel),
      .o_match  (w_match[gi]),
      .o_lane   (w_lane[gi])
    );
  end

  assign w_any_match = |w_match;
  assign w_hit       = cs && !flush && w_any_match;
  assign w_hit_lane  = w_match[0] ? w_lane[0] : w_lane[1];
  assign w_byp       = w_fill && cs && (w_line == r_pend_tag);
  assign w_byp_shift = data_read >> (DW * int'(w_sel));
  assign w_byp_lane  = w_byp_shift[DW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lru      <= 1'b0;
      r_drop     <= 1'b0;
      r_pend_tag <= '0;
      ok         <= 1'b0;
      dout       <= '0;
      req        <= 1'b0;
      sdram_addr <= '0;
    end else begin
      if (w_byp) begin
        ok   <= 1'b1;
        dout <= w_byp_lane;
      end else if (w_hit) begin
        ok   <= 1'b1;
        dout <= w_hit_lane;
      end else begin
        ok <= 1'b0;
      end

      // A fill outranks a same-edge hit: LRU must point away from the new line.
      if (w_fill)
        r_lru <= ~r_lru;
      else if (w_hit)
        r_lru <= w_match[0];

      if (flush && r_state != IDLE)
        r_drop <= 1'b1;

      case (r_state)
        IDLE: begin
          if (cs && !flush && !w_any_match) begin
            r_pend_tag <= w_line;
            sdram_addr <= line_to_sdram(OFFSET, 22'(w_line));
            req        <= 1'b1;
            r_drop     <= 1'b0;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            req     <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (data_rdy)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtbubl_rom_slot.sv
// Self-checking bench for jtbubl_rom_slot (DW=8, sound region offset):
// directed scenarios followed by random accesses against an LRU queue model.
module tb_jtbubl_rom_slot;
  import jtbubl_rom_pkg::*;

  localparam int          AW  = 15;
  localparam logic [21:0] OFS = SND_OFFSET;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          flush     = 1'b0;
  logic          cs        = 1'b0;
  logic [AW-1:0] addr      = '0;
  logic          ack       = 1'b0;
  logic          data_rdy  = 1'b0;
  logic [31:0]   data_read = '0;
  logic          ok;
  logic [7:0]    dout;
  logic          req;
  logic [21:0]   sdram_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jtbubl_rom_slot #(
    .AW    (AW),
    .DW    (8),
    .OFFSET(OFS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cs        (cs),
    .addr      (addr),
    .ok        (ok),
    .dout      (dout),
    .req       (req),
    .sdram_addr(sdram_addr),
    .ack       (ack),
    .data_rdy  (data_rdy),
    .data_read (data_read)
  );

  function automatic logic [31:0] mem_word(input int line);
    return 32'(line) * 32'h9E37_79B1 + 32'h0135_79BD;
  endfunction

  function automatic logic [31:0] lane_of(input logic [31:0] d, input int sel);
    logic [31:0] s;
    s = d >> (8 * sel);
    return {24'h0, s[7:0]};
  endfunction

  function automatic logic [31:0] exp_sdram(input int line);
    logic [31:0] s;
    s = {10'h0, OFS} + 32'(2 * line);
    return {10'h0, s[21:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Request must rise on the edge after a miss is presented.
  task automatic expect_req(input logic [AW-1:0] a, input string tag);
    int n;
    step();
    chk({tag, " req_rise"}, {31'h0, req}, 32'h1);
    n = 0;
    while (!req && n < 8) begin
      step();
      n++;
    end
    chk({tag, " sdram_addr"}, {10'h0, sdram_addr}, exp_sdram(int'(a >> 2)));
  endtask

  // Arbiter side of a fetch; a stray data_rdy during REQ must be ignored.
  task automatic complete(input logic [AW-1:0] a, input logic [31:0] d, input string tag);
    int pre;
    pre = int'($urandom_range(0, 2));
    for (int i = 0; i < pre; i++) begin
      data_rdy  = (i == 0);
      data_read = $urandom;
      step();
      data_rdy = 1'b0;
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk({tag, " req_drop"}, {31'h0, req}, 32'h0);
    repeat ($urandom_range(0, 3)) step();
    chk({tag, " ok_wait"}, {31'h0, ok}, 32'h0);
    data_rdy  = 1'b1;
    data_read = d;
    step();
    data_rdy  = 1'b0;
    data_read = $urandom;
    chk({tag, " ok"}, {31'h0, ok}, 32'h1);
    chk({tag, " dout"}, {24'h0, dout}, lane_of(d, int'(a[1:0])));
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, input logic [31:0] d, input string tag);
    cs   = 1'b1;
    addr = a;
    expect_req(a, tag);
    complete(a, d, tag);
  endtask

  initial begin
    int recent[$];
    int pool[4];
    int line, sel, idx;
    logic [AW-1:0] a;

    pool[0] = 0;
    pool[1] = 1;
    pool[2] = 13'h1ABC;
    pool[3] = 13'h1FFF;

    // Reset state
    step();
    step();
    chk("rst ok", {31'h0, ok}, 32'h0);
    chk("rst dout", {24'h0, dout}, 32'h0);
    chk("rst req", {31'h0, req}, 32'h0);
    chk("rst sdram_addr", {10'h0, sdram_addr}, 32'h0);

    // First fetch, exact timing: ack in cycle 3, data_rdy in cycle 6
    rst_n = 1'b1;
    cs    = 1'b1;
    addr  = 15'h0005;
    step();
    chk("d1 req", {31'h0, req}, 32'h1);
    chk("d1 sdram_addr", {10'h0, sdram_addr}, 32'h0001_0002);
    step();
    chk("d1 req_hold", {31'h0, req}, 32'h1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("d1 req_drop", {31'h0, req}, 32'h0);
    step();
    step();
    chk("d1 ok_before", {31'h0, ok}, 32'h0);
    data_rdy  = 1'b1;
    data_read = 32'hDDCC_BBAA;
    step();
    data_rdy  = 1'b0;
    data_read = 32'h0;
    chk("d1 ok", {31'h0, ok}, 32'h1);
    chk("d1 dout", {24'h0, dout}, 32'hBB);

    // Same line, other lane: hit, no request
    addr = 15'h0007;
    step();
    chk("d2 ok", {31'h0, ok}, 32'h1);
    chk("d2 dout", {24'h0, dout}, 32'hDD);
    chk("d2 no_req", {31'h0, req}, 32'h0);

    // LRU eviction: lines 0,1,2 then line 0 again misses
    cs    = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("d3 flush_ok", {31'h0, ok}, 32'h0);
    do_fetch(15'd0, mem_word(0), "d3 l0");
    do_fetch(15'd4, mem_word(1), "d3 l1");
    do_fetch(15'd8, mem_word(2), "d3 l2");
    do_fetch(15'd0, mem_word(0), "d3 l0_again");
    addr = 15'd8;
    step();
    chk("d3 l2_hit_ok", {31'h0, ok}, 32'h1);
    chk("d3 l2_hit_dout", {24'h0, dout}, lane_of(mem_word(2), 0));
    chk("d3 l2_hit_no_req", {31'h0, req}, 32'h0);

    // Hit on another line while a fetch is in WAIT
    addr = 15'd12;
    expect_req(15'd12, "d4 l3");
    ack = 1'b1;
    step();
    ack = 1'b0;
    addr = 15'd9;
    step();
    chk("d4 wait_hit_ok", {31'h0, ok}, 32'h1);
    chk("d4 wait_hit_dout", {24'h0, dout}, lane_of(mem_word(2), 1));
    step();
    chk("d4 wait_hit_ok2", {31'h0, ok}, 32'h1);
    data_rdy  = 1'b1;
    data_read = mem_word(3);
    step();
    data_rdy = 1'b0;
    chk("d4 fill_ok", {31'h0, ok}, 32'h1);
    chk("d4 fill_dout", {24'h0, dout}, lane_of(mem_word(2), 1));
    chk("d4 fill_no_req", {31'h0, req}, 32'h0);
    addr = 15'd13;
    step();
    chk("d4 l3_hit_ok", {31'h0, ok}, 32'h1);
    chk("d4 l3_hit_dout", {24'h0, dout}, lane_of(mem_word(3), 1));
    step();
    chk("d4 l3_hit_no_req", {31'h0, req}, 32'h0);

    // Flush during WAIT: fill discarded, same addr fetches again
    addr = 15'd0;
    expect_req(15'd0, "d5 l0");
    ack = 1'b1;
    step();
    ack   = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("d5 flush_ok", {31'h0, ok}, 32'h0);
    step();
    data_rdy  = 1'b1;
    data_read = mem_word(0);
    step();
    data_rdy = 1'b0;
    chk("d5 dropped_ok", {31'h0, ok}, 32'h0);
    expect_req(15'd0, "d5 refetch");
    complete(15'd0, mem_word(0), "d5 refetch");

    // Reset while in REQ; later data_rdy is ignored
    addr = 15'd12;
    expect_req(15'd12, "d6 l3");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cs    = 1'b0;
    chk("d6 rst_req", {31'h0, req}, 32'h0);
    chk("d6 rst_ok", {31'h0, ok}, 32'h0);
    chk("d6 rst_dout", {24'h0, dout}, 32'h0);
    data_rdy  = 1'b1;
    data_read = 32'hFFFF_FFFF;
    step();
    data_rdy = 1'b0;
    chk("d6 stray_rdy_ok", {31'h0, ok}, 32'h0);
    chk("d6 stray_rdy_req", {31'h0, req}, 32'h0);
    do_fetch(15'd0, mem_word(0), "d6 l0_after_rst");

    // Random accesses against a most-recent-two-lines model
    cs    = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("rnd flush_ok", {31'h0, ok}, 32'h0);
    recent.delete();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        cs = 1'b0;
        step();
        chk("rnd idle_ok", {31'h0, ok}, 32'h0);
        chk("rnd idle_req", {31'h0, req}, 32'h0);
      end
      line = pool[$urandom_range(0, 3)];
      sel  = int'($urandom_range(0, 3));
      a    = AW'(line * 4 + sel);
      idx  = -1;
      foreach (recent[k]) if (recent[k] == line) idx = k;
      if (idx >= 0) begin
        cs   = 1'b1;
        addr = a;
        step();
        chk("rnd hit_ok", {31'h0, ok}, 32'h1);
        chk("rnd hit_dout", {24'h0, dout}, lane_of(mem_word(line), sel));
        chk("rnd hit_no_req", {31'h0, req}, 32'h0);
        recent.delete(idx);
        recent.push_back(line);
      end else begin
        do_fetch(a, mem_word(line), "rnd miss");
        recent.push_back(line);
        if (recent.size() > 2) void'(recent.pop_front());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not reach its summary, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
